// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache frame and fetch-address layout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default icache geometry; the address struct below describes this geometry.
  localparam int unsigned ICACHE_INDEX_W   = 4;
  localparam int unsigned ICACHE_TAG_W     = 32 - ICACHE_INDEX_W - 2;
  // Frame tag field is sized for the smallest possible index so any INDEX_W fits;
  // bits above the live tag width are always written as zero.
  localparam int unsigned ICACHE_TAG_MAX_W = 30;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    word_t                       data;
  } icache_frame_t;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0]   tag;
    logic [ICACHE_INDEX_W-1:0] idx;
    logic [1:0]                bytoff;
  } icachef_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking miss FSM.
// Optional feature macro: ICACHE_STATS_EN adds hit_count / miss_count outputs.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned INDEX_W = ICACHE_INDEX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned Frames = 2 ** INDEX_W;
  localparam int unsigned TagW   = 32 - INDEX_W - 2;

  typedef enum logic {StIdle, StFetch} state_e;

  state_e        state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  icache_frame_t frames_q [Frames];

  logic [INDEX_W-1:0]          req_idx, fill_idx;
  logic [ICACHE_TAG_MAX_W-1:0] req_tag, fill_tag;
  logic                        lookup_hit;
  logic                        fill_en;

  // Lookup, miss detection, memory-side request and next-state selection.
  always_comb begin
    req_idx              = imemaddr[INDEX_W+1:2];
    fill_idx             = miss_addr_q[INDEX_W+1:2];
    req_tag              = '0;
    req_tag[TagW-1:0]    = imemaddr[31:INDEX_W+2];
    fill_tag             = '0;
    fill_tag[TagW-1:0]   = miss_addr_q[31:INDEX_W+2];
    lookup_hit           = frames_q[req_idx].valid && (frames_q[req_idx].tag == req_tag);

    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = imemaddr;
    fill_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = frames_q[req_idx].data;
          end else begin
            miss_addr_d = imemaddr;
            state_d     = StFetch;
          end
        end
      end
      StFetch: begin
        // Fill is not bypassed to the datapath; the hit shows up next cycle.
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          fill_en = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  // State, miss address, frame array and optional statistics counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      frames_q    <= '{default: '0};
`ifdef ICACHE_STATS_EN
      hit_count   <= '0;
      miss_count  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_en) begin
        frames_q[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: iload};
      end
`ifdef ICACHE_STATS_EN
      if (ihit) hit_count <= hit_count + 32'd1;
      if ((state_q == StIdle) && (state_d == StFetch)) miss_count <= miss_count + 32'd1;
`endif
    end
  end

endmodule
